// File: rtl/calc_pkg.sv
// Shared types and widths for the calculator request/response protocol.
package calc_pkg;

  localparam int ENV_CMD_SIZE  = 4;
  localparam int ENV_DATA_SIZE = 32;

  typedef enum logic [ENV_CMD_SIZE-1:0] {
    NOP = 4'd0,
    ADD = 4'd1,
    SUB = 4'd2,
    SHL = 4'd5,
    SHR = 4'd6
  } cmd_e;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    OK   = 2'd1,
    OVF  = 2'd2,
    INV  = 2'd3
  } resp_e;

  typedef struct packed {
    resp_e                     resp;
    logic [ENV_DATA_SIZE-1:0]  data;
    logic [1:0]                tag;
  } calc_result_t;

  // One slot of the response delay line.
  typedef struct packed {
    logic         valid;
    calc_result_t res;
  } calc_stage_t;

endpackage

// File: rtl/calc_alu.sv
// Combinational calculator datapath: unsigned add/sub with range check, logical shifts.
module calc_alu
  import calc_pkg::*;
(
  input  logic [ENV_CMD_SIZE-1:0]  cmd,
  input  logic [ENV_DATA_SIZE-1:0] op1,
  input  logic [ENV_DATA_SIZE-1:0] op2,
  output resp_e                    resp,
  output logic [ENV_DATA_SIZE-1:0] data
);

  localparam int SHAMT_W = $clog2(ENV_DATA_SIZE);

  logic [ENV_DATA_SIZE:0] sum;

  assign sum = {1'b0, op1} + {1'b0, op2};

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    resp = INV;
    data = '0;
    case (cmd)
      ADD: begin
        if (sum[ENV_DATA_SIZE]) begin
          resp = OVF;
        end else begin
          resp = OK;
          data = sum[ENV_DATA_SIZE-1:0];
        end
      end
      SUB: begin
        if (op2 > op1) begin
          resp = OVF;
        end else begin
          resp = OK;
          data = op1 - op2;
        end
      end
      SHL: begin
        resp = OK;
        data = op1 << op2[SHAMT_W-1:0];
      end
      SHR: begin
        resp = OK;
        data = op1 >> op2[SHAMT_W-1:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/calc_port_responder.sv
// Single-port calculator responder: two-cycle request capture, fixed-latency in-order
// response pipeline, and a per-tag outstanding table.
module calc_port_responder
  import calc_pkg::*;
#(
  parameter int LATENCY = 3
) (
  input  logic                     PClk,
  input  logic                     reset,
  input  logic [ENV_CMD_SIZE-1:0]  req_cmd_in,
  input  logic [ENV_DATA_SIZE-1:0] req_data_in,
  input  logic [1:0]               req_tag_in,
  output logic [1:0]               out_resp,
  output logic [ENV_DATA_SIZE-1:0] out_data,
  output logic [1:0]               out_tag,
  output logic                     protocol_err,
  output logic                     tag_reuse_err
);

  typedef enum logic {IDLE, OP2} state_e;

  state_e                   state_q, state_d;
  logic [ENV_CMD_SIZE-1:0]  cmd_q;
  logic [ENV_DATA_SIZE-1:0] op1_q;
  logic [1:0]               tag_q;
  logic [3:0]               outstanding_q, outstanding_d;
  calc_stage_t              pipe_q [LATENCY];
  calc_stage_t              push;

  resp_e                    alu_resp;
  logic [ENV_DATA_SIZE-1:0] alu_data;

  logic                     retire;
  logic [1:0]               retire_tag;
  logic                     tag_free;
  logic                     accept;
  logic                     reuse;
  logic                     proto;

  calc_alu u_alu (
    .cmd  (cmd_q),
    .op1  (op1_q),
    .op2  (req_data_in),
    .resp (alu_resp),
    .data (alu_data)
  );

  // The last stage is the output register; its tag retires in the cycle it is shown.
  assign retire     = pipe_q[LATENCY-1].valid;
  assign retire_tag = pipe_q[LATENCY-1].res.tag;
  assign tag_free   = !outstanding_q[req_tag_in] || (retire && retire_tag == req_tag_in);

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    reuse   = 1'b0;
    proto   = 1'b0;
    push    = '0;
    case (state_q)
      IDLE: begin
        if (req_cmd_in != '0) begin
          if (tag_free) begin
            accept  = 1'b1;
            state_d = OP2;
          end else begin
            reuse = 1'b1;
          end
        end
      end
      OP2: begin
        state_d       = IDLE;
        proto         = (req_cmd_in != '0);
        push.valid    = 1'b1;
        push.res.resp = alu_resp;
        push.res.data = alu_data;
        push.res.tag  = tag_q;
      end
      default: state_d = IDLE;
    endcase
  end

  // Clear-before-set lets a tag be reissued in the same cycle it retires.
  always_comb begin
    outstanding_d = outstanding_q;
    if (retire) outstanding_d[retire_tag] = 1'b0;
    if (accept) outstanding_d[req_tag_in] = 1'b1;
  end

  // NOTE: all state uses non-blocking assignment so every register samples pre-edge values.
  always_ff @(posedge PClk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      cmd_q         <= '0;
      op1_q         <= '0;
      tag_q         <= '0;
      outstanding_q <= '0;
      protocol_err  <= 1'b0;
      tag_reuse_err <= 1'b0;
      // NOTE: the delay line is reset, not left as plain storage, so in-flight requests vanish
      // and the outputs read zero immediately.
      for (int i = 0; i < LATENCY; i++) pipe_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      outstanding_q <= outstanding_d;
      protocol_err  <= proto;
      tag_reuse_err <= reuse;
      if (accept) begin
        cmd_q <= req_cmd_in;
        op1_q <= req_data_in;
        tag_q <= req_tag_in;
      end
      pipe_q[0] <= push;
      for (int i = 1; i < LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign out_resp = pipe_q[LATENCY-1].res.resp;
  assign out_data = pipe_q[LATENCY-1].res.data;
  assign out_tag  = pipe_q[LATENCY-1].res.tag;

endmodule
